// File: rtl/cs_rr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cs_rr_sequencer
// Purpose  : Round-robin owner of one shared 3-to-8 active-low chip-select
//            decode. Grants one requester at a time for a bounded burst and
//            inserts deselected gap cycles between owners. Drives both the
//            encoded select (index + enable) and the decoded one-hot selects.
// Revision : 1.0 - initial release
// ============================================================================
module cs_rr_sequencer #(
   parameter int N_REQ      = 8,   // fixed at 8, index width 3
   parameter int HOLD_W     = 4,   // width of hold_len
   parameter int GAP_CYCLES = 1    // deselected cycles between grants, 1..7
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_REQ-1:0]  req,
   input  logic [HOLD_W-1:0] hold_len,
   output logic [N_REQ-1:0]  sel_n,
   output logic [2:0]        sel_idx,
   output logic              sel_en,
   output logic              busy
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   localparam logic [2:0]        C_GAP_LAST = 3'(GAP_CYCLES);
   localparam logic [HOLD_W-1:0] C_HOLD_ONE = {{(HOLD_W-1){1'b0}}, 1'b1};

   // Registered state and outputs
   state_t            r_state;
   logic [2:0]        r_ptr;
   logic [HOLD_W-1:0] r_hold_cnt;
   logic [HOLD_W-1:0] r_hold_cap;
   logic [2:0]        r_gap_cnt;
   logic [N_REQ-1:0]  r_sel_n;
   logic [2:0]        r_sel_idx;
   logic              r_sel_en;
   logic              r_busy;

   // Next-state values
   state_t            w_state_nxt;
   logic [2:0]        w_ptr_nxt;
   logic [HOLD_W-1:0] w_hold_cnt_nxt;
   logic [HOLD_W-1:0] w_hold_cap_nxt;
   logic [2:0]        w_gap_cnt_nxt;
   logic [N_REQ-1:0]  w_sel_n_nxt;
   logic [2:0]        w_sel_idx_nxt;
   logic              w_sel_en_nxt;
   logic              w_busy_nxt;

   // Arbitration helpers
   logic [2*N_REQ-1:0] w_req_dbl;
   logic [N_REQ-1:0]   w_req_rot;
   logic [2:0]         w_off;
   logic [2:0]         w_win;
   logic [N_REQ-1:0]   w_win_sel_n;
   logic               w_any_req;
   logic [HOLD_W-1:0]  w_hold_eff;
   logic               w_owner_req;
   logic               w_burst_done;

   assign w_req_dbl   = {req, req};
   // Rotate so that bit 0 of w_req_rot corresponds to requester r_ptr
   assign w_req_rot   = w_req_dbl[r_ptr +: N_REQ];
   assign w_any_req   = |req;
   assign w_win       = r_ptr + w_off;
   assign w_win_sel_n = ~(N_REQ'(1) << w_win);
   // A zero burst length still yields a one-cycle grant
   assign w_hold_eff  = (hold_len == '0) ? C_HOLD_ONE : hold_len;
   assign w_owner_req = req[r_sel_idx];
   assign w_burst_done = (r_hold_cnt == r_hold_cap);

   // Lowest set bit of the rotated request vector = offset of the winner from ptr
   always_comb begin
      w_off = 3'd0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (w_req_rot[i]) begin
            w_off = 3'(i);
         end
      end
   end

   // Next-state and next-output decode for the IDLE/GRANT/GAP sequencer
   always_comb begin
      w_state_nxt    = r_state;
      w_ptr_nxt      = r_ptr;
      w_hold_cnt_nxt = r_hold_cnt;
      w_hold_cap_nxt = r_hold_cap;
      w_gap_cnt_nxt  = r_gap_cnt;
      w_sel_n_nxt    = r_sel_n;
      w_sel_idx_nxt  = r_sel_idx;
      w_sel_en_nxt   = r_sel_en;
      w_busy_nxt     = r_busy;

      case (r_state)
         ST_IDLE: begin
            if (w_any_req) begin
               w_state_nxt    = ST_GRANT;
               w_hold_cnt_nxt = C_HOLD_ONE;
               w_hold_cap_nxt = w_hold_eff;
               w_sel_n_nxt    = w_win_sel_n;
               w_sel_idx_nxt  = w_win;
               w_sel_en_nxt   = 1'b1;
               w_busy_nxt     = 1'b1;
            end else begin
               w_sel_n_nxt    = '1;
               w_sel_idx_nxt  = 3'd0;
               w_sel_en_nxt   = 1'b0;
               w_busy_nxt     = 1'b0;
            end
         end

         ST_GRANT: begin
            // Release and burst expiry on the same edge collapse to one exit
            if (!w_owner_req || w_burst_done) begin
               w_state_nxt   = ST_GAP;
               w_ptr_nxt     = r_sel_idx + 3'd1;
               w_gap_cnt_nxt = 3'd1;
               w_sel_n_nxt   = '1;
               w_sel_en_nxt  = 1'b0;
               w_busy_nxt    = 1'b1;
            end else begin
               w_hold_cnt_nxt = r_hold_cnt + C_HOLD_ONE;
            end
         end

         ST_GAP: begin
            if (r_gap_cnt >= C_GAP_LAST) begin
               if (w_any_req) begin
                  w_state_nxt    = ST_GRANT;
                  w_hold_cnt_nxt = C_HOLD_ONE;
                  w_hold_cap_nxt = w_hold_eff;
                  w_sel_n_nxt    = w_win_sel_n;
                  w_sel_idx_nxt  = w_win;
                  w_sel_en_nxt   = 1'b1;
                  w_busy_nxt     = 1'b1;
               end else begin
                  w_state_nxt    = ST_IDLE;
                  w_sel_n_nxt    = '1;
                  w_sel_idx_nxt  = 3'd0;
                  w_sel_en_nxt   = 1'b0;
                  w_busy_nxt     = 1'b0;
               end
            end else begin
               w_gap_cnt_nxt = r_gap_cnt + 3'd1;
            end
         end

         default: begin
            w_state_nxt    = ST_IDLE;
            w_hold_cnt_nxt = '0;
            w_gap_cnt_nxt  = 3'd0;
            w_sel_n_nxt    = '1;
            w_sel_idx_nxt  = 3'd0;
            w_sel_en_nxt   = 1'b0;
            w_busy_nxt     = 1'b0;
         end
      endcase
   end

   // State and output registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_ptr      <= 3'd0;
         r_hold_cnt <= '0;
         r_hold_cap <= C_HOLD_ONE;
         r_gap_cnt  <= 3'd0;
         r_sel_n    <= '1;
         r_sel_idx  <= 3'd0;
         r_sel_en   <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_ptr      <= w_ptr_nxt;
         r_hold_cnt <= w_hold_cnt_nxt;
         r_hold_cap <= w_hold_cap_nxt;
         r_gap_cnt  <= w_gap_cnt_nxt;
         r_sel_n    <= w_sel_n_nxt;
         r_sel_idx  <= w_sel_idx_nxt;
         r_sel_en   <= w_sel_en_nxt;
         r_busy     <= w_busy_nxt;
      end
   end

   assign sel_n   = r_sel_n;
   assign sel_idx = r_sel_idx;
   assign sel_en  = r_sel_en;
   assign busy    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_cs_rr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cs_rr_sequencer
// Purpose  : Directed table-driven bench for cs_rr_sequencer, plus hand
//            sequences for reset behaviour and a continuous one-hot monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cs_rr_sequencer;

   logic       clk;
   logic       rst_n;
   logic [7:0] req;
   logic [3:0] hold_len;
   logic [7:0] sel_n;
   logic [2:0] sel_idx;
   logic       sel_en;
   logic       busy;

   int n_tests;
   int n_fail;
   bit mon_on;

   typedef struct {
      logic [7:0] req;
      logic [3:0] hold;
      logic [7:0] sel_n;
      logic [2:0] idx;
      logic       en;
      logic       busy;
   } vec_t;

   vec_t tv[$];

   cs_rr_sequencer #(
      .N_REQ      (8),
      .HOLD_W     (4),
      .GAP_CYCLES (1)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .hold_len (hold_len),
      .sel_n    (sel_n),
      .sel_idx  (sel_idx),
      .sel_en   (sel_en),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [7:0] e_sel_n, input logic [2:0] e_idx,
                          input logic e_en, input logic e_busy);
      chk({tag, " sel_n"},   sel_n,          e_sel_n);
      chk({tag, " sel_idx"}, {5'd0, sel_idx}, {5'd0, e_idx});
      chk({tag, " sel_en"},  {7'd0, sel_en},  {7'd0, e_en});
      chk({tag, " busy"},    {7'd0, busy},    {7'd0, e_busy});
   endtask

   task automatic add(input logic [7:0] r, input logic [3:0] h, input logic [7:0] s,
                      input logic [2:0] i, input logic e, input logic b);
      vec_t v;
      v.req = r; v.hold = h; v.sel_n = s; v.idx = i; v.en = e; v.busy = b;
      tv.push_back(v);
   endtask

   // At most one select low, and the enable agrees with the decoded selects
   always @(negedge clk) begin
      if (mon_on) begin
         n_tests++;
         if ($countones(~sel_n) > 1 || (sel_en && sel_n[sel_idx] !== 1'b0) ||
             (!sel_en && sel_n !== 8'hFF)) begin
            n_fail++;
            $display("FAIL onehot: sel_n=%h sel_idx=%0d sel_en=%b", sel_n, sel_idx, sel_en);
         end
      end
   end

   initial begin
      n_tests  = 0;
      n_fail   = 0;
      mon_on   = 1'b0;
      rst_n    = 1'b0;
      req      = 8'hFF;
      hold_len = 4'd3;

      // Single request, hold 3
      add(8'h04, 4'd3, 8'hFB, 3'd2, 1'b1, 1'b1);
      add(8'h04, 4'd3, 8'hFB, 3'd2, 1'b1, 1'b1);
      add(8'h04, 4'd3, 8'hFB, 3'd2, 1'b1, 1'b1);
      add(8'h04, 4'd3, 8'hFF, 3'd2, 1'b0, 1'b1);
      add(8'h04, 4'd3, 8'hFB, 3'd2, 1'b1, 1'b1);
      add(8'h04, 4'd3, 8'hFB, 3'd2, 1'b1, 1'b1);
      add(8'h04, 4'd3, 8'hFB, 3'd2, 1'b1, 1'b1);
      add(8'h04, 4'd3, 8'hFF, 3'd2, 1'b0, 1'b1);
      add(8'h00, 4'd3, 8'hFF, 3'd0, 1'b0, 1'b0);
      add(8'h00, 4'd3, 8'hFF, 3'd0, 1'b0, 1'b0);
      // Round robin 0/7, ptr=3 at start so 7 wins first
      add(8'h81, 4'd2, 8'h7F, 3'd7, 1'b1, 1'b1);
      add(8'h81, 4'd2, 8'h7F, 3'd7, 1'b1, 1'b1);
      add(8'h81, 4'd2, 8'hFF, 3'd7, 1'b0, 1'b1);
      add(8'h81, 4'd2, 8'hFE, 3'd0, 1'b1, 1'b1);
      add(8'h81, 4'd2, 8'hFE, 3'd0, 1'b1, 1'b1);
      add(8'h81, 4'd2, 8'hFF, 3'd0, 1'b0, 1'b1);
      add(8'h81, 4'd2, 8'h7F, 3'd7, 1'b1, 1'b1);
      add(8'h81, 4'd2, 8'h7F, 3'd7, 1'b1, 1'b1);
      add(8'h81, 4'd2, 8'hFF, 3'd7, 1'b0, 1'b1);
      add(8'h81, 4'd2, 8'hFE, 3'd0, 1'b1, 1'b1);
      add(8'h00, 4'd2, 8'hFF, 3'd0, 1'b0, 1'b1);
      add(8'h00, 4'd2, 8'hFF, 3'd0, 1'b0, 1'b0);
      // Early release with hold 10
      add(8'h02, 4'd10, 8'hFD, 3'd1, 1'b1, 1'b1);
      add(8'h02, 4'd10, 8'hFD, 3'd1, 1'b1, 1'b1);
      add(8'h00, 4'd10, 8'hFF, 3'd1, 1'b0, 1'b1);
      add(8'h00, 4'd10, 8'hFF, 3'd0, 1'b0, 1'b0);
      // hold_len = 0 behaves as 1
      add(8'h02, 4'd0, 8'hFD, 3'd1, 1'b1, 1'b1);
      add(8'h02, 4'd0, 8'hFF, 3'd1, 1'b0, 1'b1);
      add(8'h02, 4'd0, 8'hFD, 3'd1, 1'b1, 1'b1);
      add(8'h02, 4'd0, 8'hFF, 3'd1, 1'b0, 1'b1);
      add(8'h00, 4'd0, 8'hFF, 3'd0, 1'b0, 1'b0);
      // hold_len changed 2 -> 8 mid-burst: burst still 2 cycles
      add(8'h02, 4'd2, 8'hFD, 3'd1, 1'b1, 1'b1);
      add(8'h02, 4'd8, 8'hFD, 3'd1, 1'b1, 1'b1);
      add(8'h02, 4'd8, 8'hFF, 3'd1, 1'b0, 1'b1);
      add(8'h00, 4'd8, 8'hFF, 3'd0, 1'b0, 1'b0);
      // Wrap: grant 6 leaves ptr=7; release coincides with count reaching 1
      add(8'h40, 4'd1, 8'hBF, 3'd6, 1'b1, 1'b1);
      add(8'h00, 4'd1, 8'hFF, 3'd6, 1'b0, 1'b1);
      add(8'h00, 4'd1, 8'hFF, 3'd0, 1'b0, 1'b0);
      add(8'h81, 4'd1, 8'h7F, 3'd7, 1'b1, 1'b1);
      add(8'h81, 4'd1, 8'hFF, 3'd7, 1'b0, 1'b1);
      add(8'h81, 4'd1, 8'hFE, 3'd0, 1'b1, 1'b1);
      add(8'h00, 4'd1, 8'hFF, 3'd0, 1'b0, 1'b1);
      add(8'h00, 4'd1, 8'hFF, 3'd0, 1'b0, 1'b0);

      // Reset held with every request active
      repeat (3) @(posedge clk);
      #1;
      chk_all("reset", 8'hFF, 3'd0, 1'b0, 1'b0);
      req   = 8'h00;
      rst_n = 1'b1;
      mon_on = 1'b1;

      for (int k = 0; k < tv.size(); k++) begin
         req      = tv[k].req;
         hold_len = tv[k].hold;
         @(posedge clk);
         #1;
         chk_all($sformatf("vec%0d", k), tv[k].sel_n, tv[k].idx, tv[k].en, tv[k].busy);
      end

      // Asynchronous reset in the middle of a grant (ptr=1 here, 0 still wins)
      req      = 8'h01;
      hold_len = 4'd4;
      @(posedge clk);
      #1;
      chk_all("pre_async", 8'hFE, 3'd0, 1'b1, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_all("async_rst", 8'hFF, 3'd0, 1'b0, 1'b0);
      // After release arbitration restarts from index 0
      req   = 8'hFF;
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk_all("post_rst", 8'hFE, 3'd0, 1'b1, 1'b1);
      req = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk_all("final_idle", 8'hFF, 3'd0, 1'b0, 1'b0);

      mon_on = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/cs_rr_sequencer.md
Name: cs_rr_sequencer

Overview:
- Clocked controller that shares one 3-to-8 active-low chip-select decode among 8 requesters.
- Grants one requester at a time using round-robin priority and holds the grant for a bounded burst.
- Inserts an all-deselected gap cycle between owners to avoid select overlap and glitch power.
- Drives both the encoded select (index + enable) for a downstream decoder and the decoded active-low one-hot selects directly.

Parameters:
- N_REQ, 8, number of requesters; fixed at 8 (index width 3).
- HOLD_W, 4, width of burst-length input hold_len.
- GAP_CYCLES, 1, deselected cycles between grants; legal range 1..7.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  8  per-requester level request; req[i] high = wants select i.
- hold_len  input  HOLD_W  max grant length in cycles; 0 treated as 1.
- sel_n  output  8  active-low one-hot chip selects; all ones = none selected.
- sel_idx  output  3  encoded index of current owner.
- sel_en  output  1  active-high decoder enable; 1 only while a grant is active.
- busy  output  1  high in GRANT or GAP states.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. All outputs and state are registered.
- Reset values: sel_n=8'hFF, sel_idx=0, sel_en=0, busy=0, state=IDLE, rr pointer ptr=0, hold counter=0, gap counter=0.
  - Asserting rst_n low mid-grant forces these values immediately, with no wait for clk.
  - After release, the first arbitration starts at index 0.
- States: IDLE, GRANT, GAP. Any unencoded state returns to IDLE on the next edge.
- Arbitration:
  - Winner = first i with req[i]=1, scanning ptr, ptr+1, … ptr+7 modulo 8.
  - ptr is updated to winner+1 (mod 8) when a grant ends.
- IDLE:
  - If |req at edge k, then at edge k the block enters GRANT with the winner, so sel_n[w]=0, sel_idx=w, sel_en=1, busy=1 are visible after edge k.
  - Latency is one cycle from req sampled high to select asserted.
  - Otherwise stay in IDLE with all outputs at reset values.
- GRANT:
  - hold_len is captured at grant start; later changes do not affect the current burst.
  - The hold counter counts grant cycles starting at 1.
  - Exit to GAP at the edge where req[owner]=0 or count==captured hold_len (max of hold_len and 1).
  - Entering GAP: sel_n=8'hFF, sel_en=0, sel_idx keeps its last value, busy=1, gap counter=1.
  - Requests from other indices during GRANT are ignored.
- GAP:
  - Lasts exactly GAP_CYCLES cycles.
  - At the last gap edge: if |req, enter GRANT with a new winner using the updated ptr; else go to IDLE (busy=0).
  - The previous owner can win again only if no other index requests (it has the lowest priority after ptr update).
- Invariants:
  - sel_n is either all ones or has exactly one zero.
  - sel_n[sel_idx]==~sel_en whenever sel_en=1.
  - No cycle has two selects low. Between any two grants there are ≥GAP_CYCLES cycles with sel_n=8'hFF.
- Simultaneous events: if req[owner] drops on the same edge the count reaches hold_len, the result is a single exit to GAP (no double count).
- Wrap-around: with ptr=7 and req={0,7}, the scan order is 7, 0, … so 7 wins; after the grant ptr=0.

Test Plan:
- Reset: hold rst_n=0, req=8'hFF -> sel_n=8'hFF, sel_en=0, busy=0. Pulse rst_n low mid-grant -> outputs return to reset values before the next clk edge.
- Single request: req=8'h04 from cycle 0, hold_len=3, GAP_CYCLES=1 -> sel_n=8'hFB for cycles 1-3, 8'hFF in cycle 4, 8'hFB again for cycles 5-7.
- Round robin: req=8'h81 held constant, hold_len=2 -> owners alternate 0,7,0,7 with one deselected cycle between each; sel_idx 0/7 accordingly.
- Early release: req=8'h02, hold_len=10, req[1] dropped after 2 grant cycles -> grant lasts 2 cycles, then GAP, then IDLE with busy=0.
- hold_len=0 and mid-burst change: hold_len=0 -> 1-cycle grants. Changing hold_len from 2 to 8 during a grant -> the current burst still ends after 2 cycles.
- Wrap: force ptr=7 via a prior grant of index 6, req=8'h81 -> index 7 granted first, then index 0. Throughout, the bench checks that sel_n never has more than one zero.
